// File: rtl/dff_resp_checker.sv
// dff_resp_checker: golden-model response checker for single-bit flip-flop DUTs.
// A LAT-deep synchronous-reset DFF model runs beside the DUT; tagged samples
// are compared at the chain output and summarised as err_cnt / first_fail / pass.
module dff_resp_checker #(
    parameter int LAT   = 1,
    parameter int NSAMP = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stim_valid,
    input  logic             stim_d,
    input  logic             dut_rst_n,
    input  logic             dut_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_fail
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] ALL_ONES   = '1;
    localparam logic [CNT_W-1:0] LAST_INDEX = CNT_W'(NSAMP - 1);
    localparam logic [2:0]       ARM_LAST   = 3'(LAT - 1);

    state_t           state;
    state_t           next_state;
    logic [LAT-1:0]   chain;
    logic [LAT-1:0]   tags;
    logic [2:0]       arm_cnt;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_next;
    logic             compare;
    logic             mismatch;
    logic             last_sample;
    logic             accept_start;

    // A compare happens only in RUN, when a tagged sample reaches the chain output.
    // Case-inequality makes an X/Z on dut_q count as a mismatch in simulation.
    assign compare      = (state == RUN) && tags[LAT-1];
    assign mismatch     = compare && (dut_q !== chain[LAT-1]);
    assign last_sample  = compare && (sample_cnt == LAST_INDEX);
    assign accept_start = start && ((state == IDLE) || (state == DONE));
    assign err_next     = (mismatch && (err_cnt != ALL_ONES)) ? err_cnt + 1'b1 : err_cnt;

    // State register; checker reset wins over everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start only honoured from IDLE or DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start)                 next_state = ARM;
            ARM:  if (arm_cnt == ARM_LAST)   next_state = RUN;
            RUN:  if (last_sample)           next_state = DONE;
            DONE: if (start)                 next_state = ARM;
            default:                         next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state, so they are glitch-free.
    always_comb begin
        busy = (state == ARM) || (state == RUN);
        done = (state == DONE);
    end

    // ARM dwell counter: restarts whenever we are outside ARM so each run gets exactly LAT cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arm_cnt <= '0;
        end else if (state != ARM) begin
            arm_cnt <= '0;
        end else begin
            arm_cnt <= arm_cnt + 1'b1;
        end
    end

    // Golden DFF chain with a parallel tag chain; tags are only admitted while in RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
            tags  <= '0;
        end else begin
            chain[0] <= dut_rst_n & stim_d;
            tags[0]  <= stim_valid & (state == RUN);
            for (int k = 1; k < LAT; k++) begin
                chain[k] <= chain[k-1];
                tags[k]  <= tags[k-1];
            end
        end
    end

    // Result bookkeeping: cleared on an accepted start, updated on each compare,
    // and pass latched together with the final compare so it includes that sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            first_fail <= ALL_ONES;
            pass       <= 1'b0;
        end else if (accept_start) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            first_fail <= ALL_ONES;
            pass       <= 1'b0;
        end else if (compare) begin
            sample_cnt <= sample_cnt + 1'b1;
            err_cnt    <= err_next;
            if (mismatch && (first_fail == ALL_ONES)) begin
                first_fail <= sample_cnt;
            end
            if (last_sample) begin
                pass <= (err_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_dff_resp_checker.sv
// tb_dff_resp_checker: drives a behavioural dff_syn DUT and the checker from the
// same stimulus; expected run results are queued when a run is driven and
// compared when the checker raises done.
module tb_dff_resp_checker;

    localparam int LAT   = 1;
    localparam int NSAMP = 16;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic             pass;
        logic [CNT_W-1:0] err;
        logic [CNT_W-1:0] ff;
    } result_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stim_valid = 1'b0;
    logic             stim_d = 1'b0;
    logic             dut_rst_n = 1'b1;
    logic             stim_flip = 1'b0;
    logic             dut_q;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_fail;

    logic             q_ref = 1'b0;
    logic             flip_q = 1'b0;

    result_t          sb_q[$];
    int               checks_total  = 0;
    int               checks_passed = 0;

    dff_resp_checker #(.LAT(LAT), .NSAMP(NSAMP), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stim_valid (stim_valid),
        .stim_d     (stim_d),
        .dut_rst_n  (dut_rst_n),
        .dut_q      (dut_q),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .first_fail (first_fail)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural dff_syn under check, with a fault bit that travels alongside the data.
    always @(posedge clk) begin
        q_ref  <= dut_rst_n ? stim_d : 1'b0;
        flip_q <= stim_flip;
    end

    assign dut_q = q_ref ^ flip_q;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic rst_bit, input logic d, input logic flip);
        stim_valid = valid;
        dut_rst_n  = rst_bit;
        stim_d     = d;
        stim_flip  = flip;
        tick();
        stim_valid = 1'b0;
        stim_flip  = 1'b0;
        dut_rst_n  = 1'b1;
    endtask

    task automatic startRun();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("done_cleared", 32'(done), 32'd0);
        repeat (LAT) tick();
    endtask

    // Drives one full run; rst_pat drives dut_rst_n low on even samples with d=1,
    // start_at pulses start on that sample index (must be ignored while busy).
    task automatic playRun(input logic [15:0] flip_mask, input bit bubbles, input bit rst_pat,
                           input int start_at);
        result_t exp_res;
        int      idx;
        int      cyc;
        int      wait_cnt;
        exp_res.err = '0;
        exp_res.ff  = '1;
        for (int i = 0; i < NSAMP; i++) begin
            if (flip_mask[i]) begin
                exp_res.err = exp_res.err + 1'b1;
                if (exp_res.ff == '1) exp_res.ff = CNT_W'(i);
            end
        end
        exp_res.pass = (exp_res.err == '0);
        sb_q.push_back(exp_res);

        startRun();
        idx = 0;
        cyc = 0;
        while (idx < NSAMP) begin
            if (bubbles && cyc[0]) begin
                applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
                checkOutput("busy_in_gap", 32'(busy), 32'd1);
            end else begin
                start = (idx == start_at);
                if (rst_pat) begin
                    applyStimulus(1'b1, idx[0], 1'b1, flip_mask[idx]);
                end else begin
                    applyStimulus(1'b1, 1'b1, (idx % 3) != 1, flip_mask[idx]);
                end
                start = 1'b0;
                idx++;
            end
            cyc++;
        end
        checkOutput("done_not_early", 32'(done), 32'd0);

        wait_cnt = 0;
        while (!done && wait_cnt < 8) begin
            tick();
            wait_cnt++;
        end
        checkOutput("done_latency", 32'(wait_cnt), 32'd1);
        checkOutput("busy_at_done", 32'(busy), 32'd0);

        if (sb_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp_res = sb_q.pop_front();
            checkOutput("pass", 32'(pass), 32'(exp_res.pass));
            checkOutput("err_cnt", 32'(err_cnt), 32'(exp_res.err));
            checkOutput("first_fail", 32'(first_fail), 32'(exp_res.ff));
        end
        tick();
        checkOutput("done_held", 32'(done), 32'd1);
    endtask

    // Top-level test sequence.
    initial begin
        // Reset held with start asserted: reset must win.
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_first_fail", 32'(first_fail), 32'hFF);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Clean run.
        playRun(16'h0000, 1'b0, 1'b0, -1);
        // DUT-reset samples: dut_rst_n low with d=1 must expect 0.
        playRun(16'h0000, 1'b0, 1'b1, -1);
        // Injected faults at samples 3 and 9.
        playRun(16'h0208, 1'b0, 1'b0, -1);
        // Bubbles between every valid sample.
        playRun(16'h0000, 1'b1, 1'b0, -1);

        // Abort mid-run after 7 samples, one of them faulty.
        startRun();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b1, i[0], i == 2);
        end
        checkOutput("pre_abort_err", 32'(err_cnt), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("abort_first_fail", 32'(first_fail), 32'hFF);
        checkOutput("abort_pass", 32'(pass), 32'd0);
        tick();

        // Fresh run after abort, with a stray start pulse mid-run.
        playRun(16'h0000, 1'b0, 1'b0, 5);
        // Fault on the very last sample must still clear pass.
        playRun(16'h8000, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $display("%0d/%0d checks passed", checks_passed, checks_total + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
